// File: rtl/vga_sync_timing_pkg.sv
// rtl/vga_sync_timing_pkg.sv - default 640x480 VGA timing constants and helpers
package vga_sync_timing_pkg;

   // 640x480 @ 60 Hz horizontal timing, in pixels
   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   // 640x480 @ 60 Hz vertical timing, in lines
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // Sync polarity: 0 = active-low, 1 = active-high
   localparam int SYNC_ACTIVE_LOW  = 0;
   localparam int SYNC_ACTIVE_HIGH = 1;

   // Blanking length of one axis: everything that is not active area
   function automatic int blank_len(input int front, input int sync, input int back);
      return front + sync + back;
   endfunction

endpackage

// File: rtl/vga_sync_timing_if.sv
// rtl/vga_sync_timing_if.sv - raster timing bundle from the generator to the pixel stages
interface vga_sync_timing_if;
   logic               hsync;
   logic               vsync;
   logic               display_on;
   logic signed [15:0] hpos;
   logic signed [15:0] vpos;
   logic               line_start;
   logic               frame_start;

   // Timing generator drives the bundle
   modport master (
      output hsync, vsync, display_on, hpos, vpos, line_start, frame_start
   );

   // Pixel/pattern stages consume it
   modport slave (
      input hsync, vsync, display_on, hpos, vpos, line_start, frame_start
   );
endinterface

// File: rtl/vga_sync_timing_axis.sv
// rtl/vga_sync_timing_axis.sv - one raster axis: signed position counter with sync/active decode
module sync_axis_counter
   import vga_sync_timing_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF,
   parameter int POL     = SYNC_ACTIVE_LOW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc_i,
   output logic signed [15:0] pos_o,
   output logic               sync_o,
   output logic               active_o,
   output logic               wrap_o
);

   localparam int BLANK = blank_len(FRONT, SYNC, BACK);

   // Blanking sits at negative positions so bit 15 flags "in blanking"
   localparam logic signed [15:0] POS_FIRST  = 16'(-BLANK);
   localparam logic signed [15:0] POS_LAST   = 16'(DISPLAY - 1);
   localparam logic signed [15:0] SYNC_FIRST = 16'(FRONT - BLANK);
   localparam logic signed [15:0] SYNC_LAST  = 16'(FRONT + SYNC - 1 - BLANK);
   localparam logic               SYNC_ON    = (POL != 0);

   logic signed [15:0] pos_q, pos_d;
   logic               sync_q, sync_d;
   logic               active_q, active_d;

   // Wrap is combinational so the next axis can advance on the same edge
   assign wrap_o = inc_i && (pos_q == POS_LAST);

   // Next position and the decode of that next position, so flags carry no lag
   always_comb begin
      pos_d = pos_q;
      if (inc_i) begin
         pos_d = wrap_o ? POS_FIRST : pos_q + 16'sd1;
      end
      sync_d   = (pos_d >= SYNC_FIRST && pos_d <= SYNC_LAST) ? SYNC_ON : ~SYNC_ON;
      active_d = ~pos_d[15];
   end

   // Position and decoded flags registered together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q    <= POS_FIRST;
         sync_q   <= ~SYNC_ON;
         active_q <= 1'b0;
      end else begin
         pos_q    <= pos_d;
         sync_q   <= sync_d;
         active_q <= active_d;
      end
   end

   assign pos_o    = pos_q;
   assign sync_o   = sync_q;
   assign active_o = active_q;

endmodule

// File: rtl/vga_sync_timing.sv
// rtl/vga_sync_timing.sv - VGA raster timing generator top; VGA_SYNC_TIMING_CLK_DIV2_EN halves the pixel rate
module vga_sync_timing
   import vga_sync_timing_pkg::*;
#(
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int HSYNC_POL = SYNC_ACTIVE_LOW,
   parameter int VSYNC_POL = SYNC_ACTIVE_LOW
) (
   input  logic              clk,
   input  logic              reset,
   vga_sync_timing_if.master vga
);

   logic               adv;
   logic signed [15:0] h_pos, v_pos;
   logic               h_sync, v_sync;
   logic               h_active, v_active;
   logic               h_wrap, v_wrap;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

`ifdef VGA_SYNC_TIMING_CLK_DIV2_EN
   logic toggle_q, toggle_d;

   assign toggle_d = ~toggle_q;

   // Pixel enable on every second clock; first advance is the 2nd clock after release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toggle_q <= 1'b0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign adv = toggle_q;
`else
   assign adv = 1'b1;
`endif

   sync_axis_counter #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .POL     (HSYNC_POL)
   ) u_h (
      .clk      (clk),
      .reset    (reset),
      .inc_i    (adv),
      .pos_o    (h_pos),
      .sync_o   (h_sync),
      .active_o (h_active),
      .wrap_o   (h_wrap)
   );

   sync_axis_counter #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .POL     (VSYNC_POL)
   ) u_v (
      .clk      (clk),
      .reset    (reset),
      .inc_i    (h_wrap),
      .pos_o    (v_pos),
      .sync_o   (v_sync),
      .active_o (v_active),
      .wrap_o   (v_wrap)
   );

   // v_wrap already implies h_wrap, since the vertical axis only moves on a line wrap
   assign line_start_d  = h_wrap;
   assign frame_start_d = v_wrap;

   // Strobes land on the clock where the wrapped position first appears
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hpos        = h_pos;
   assign vga.vpos        = v_pos;
   assign vga.hsync       = h_sync;
   assign vga.vsync       = v_sync;
   assign vga.display_on  = h_active & v_active;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// tb/tb_vga_sync_timing.sv - directed checks of the VGA timing generator (small and default geometry)
module tb_vga_sync_timing;

`ifdef VGA_SYNC_TIMING_CLK_DIV2_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 1;
`endif

   // Small geometry: H 8/2/3/1 (blank 6, line 14), V 4/1/2/1 (blank 4, 8 lines)
   localparam int LINE  = 14;
   localparam int FRAME = 112;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   vga_sync_timing_if s_if ();
   vga_sync_timing_if d_if ();

   vga_sync_timing #(
      .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (1),
      .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .HSYNC_POL (0), .VSYNC_POL (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vga   (s_if)
   );

   vga_sync_timing dut_def (
      .clk   (clk),
      .reset (reset),
      .vga   (d_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int  cnt;
      bit  seen;
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (s_if.hpos !== -16'sd6) begin errors++; $display("FAIL reset_hpos: got %0d expected -6", s_if.hpos); end
      checks++; if (s_if.vpos !== -16'sd4) begin errors++; $display("FAIL reset_vpos: got %0d expected -4", s_if.vpos); end
      checks++; if (s_if.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", s_if.hsync); end
      checks++; if (s_if.vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", s_if.vsync); end
      checks++; if (s_if.display_on !== 1'b0) begin errors++; $display("FAIL reset_display_on: got %b expected 0", s_if.display_on); end
      checks++; if (s_if.line_start !== 1'b0) begin errors++; $display("FAIL reset_line_start: got %b expected 0", s_if.line_start); end
      checks++; if (s_if.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", s_if.frame_start); end
      checks++; if (d_if.hpos !== 16'hFF60) begin errors++; $display("FAIL reset_def_hpos: got %h expected ff60", d_if.hpos); end
      checks++; if (d_if.vpos !== 16'hFFD3) begin errors++; $display("FAIL reset_def_vpos: got %h expected ffd3", d_if.vpos); end
      reset = 1'b0;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 200) begin
         tick();
         cnt++;
         if (s_if.line_start === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || cnt != LINE * DIV) begin
         errors++; $display("FAIL first_line_start: got %0d clk expected %0d", cnt, LINE * DIV);
      end
   endtask

   task automatic test_line(input int want_v);
      int               cnt;
      int               exp_h;
      logic signed [15:0] eh;
      logic signed [15:0] ev;
      cnt = 0;
      ev = 16'(want_v);
      while (!(s_if.line_start === 1'b1 && s_if.vpos === ev) && cnt < 300 * DIV) begin
         tick();
         cnt++;
      end
      checks++;
      if (cnt >= 300 * DIV) begin errors++; $display("FAIL line_wait v=%0d: got timeout expected line start", want_v); end
      for (int i = 0; i < LINE * DIV; i++) begin
         if (i > 0) tick();
         exp_h = -6 + i / DIV;
         eh = 16'(exp_h);
         checks++; if (s_if.hpos !== eh) begin errors++; $display("FAIL line_hpos v=%0d i=%0d: got %0d expected %0d", want_v, i, s_if.hpos, exp_h); end
         checks++; if (s_if.vpos !== ev) begin errors++; $display("FAIL line_vpos v=%0d i=%0d: got %0d expected %0d", want_v, i, s_if.vpos, want_v); end
         checks++; if (s_if.hsync !== ((exp_h >= -4 && exp_h <= -2) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL line_hsync v=%0d h=%0d: got %b", want_v, exp_h, s_if.hsync); end
         checks++; if (s_if.display_on !== ((exp_h >= 0 && want_v >= 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL line_display_on v=%0d h=%0d: got %b", want_v, exp_h, s_if.display_on); end
         checks++; if (s_if.line_start !== (i == 0)) begin errors++; $display("FAIL line_strobe v=%0d i=%0d: got %b expected %b", want_v, i, s_if.line_start, (i == 0)); end
      end
      tick();
      checks++; if (s_if.line_start !== 1'b1 || s_if.hpos !== -16'sd6) begin errors++; $display("FAIL line_period v=%0d: got ls=%b h=%0d expected ls=1 h=-6", want_v, s_if.line_start, s_if.hpos); end
   endtask

   task automatic test_frame();
      int               cnt, n, vs_low, disp, ls, fs_hi;
      logic signed [15:0] prev_h, prev_v;
      cnt = 0;
      do begin
         prev_h = s_if.hpos;
         prev_v = s_if.vpos;
         tick();
         cnt++;
      end while (s_if.frame_start !== 1'b1 && cnt < 300 * DIV);
      checks++; if (prev_h !== 16'sd7 || prev_v !== 16'sd3) begin errors++; $display("FAIL frame_prev: got h=%0d v=%0d expected h=7 v=3", prev_h, prev_v); end
      checks++; if (s_if.hpos !== -16'sd6 || s_if.vpos !== -16'sd4) begin errors++; $display("FAIL frame_wrap: got h=%0d v=%0d expected h=-6 v=-4", s_if.hpos, s_if.vpos); end
      n = 0; vs_low = 0; disp = 0; ls = 0; fs_hi = 0;
      do begin
         if (s_if.vsync === 1'b0) vs_low++;
         if (s_if.display_on === 1'b1) disp++;
         if (s_if.line_start === 1'b1) ls++;
         if (s_if.frame_start === 1'b1) fs_hi++;
         tick();
         n++;
      end while (s_if.frame_start !== 1'b1 && n < 300 * DIV);
      checks++; if (n != FRAME * DIV) begin errors++; $display("FAIL frame_period: got %0d expected %0d", n, FRAME * DIV); end
      checks++; if (vs_low != 28 * DIV) begin errors++; $display("FAIL frame_vsync_low: got %0d expected %0d", vs_low, 28 * DIV); end
      checks++; if (disp != 32 * DIV) begin errors++; $display("FAIL frame_display_on: got %0d expected %0d", disp, 32 * DIV); end
      checks++; if (ls != 8) begin errors++; $display("FAIL frame_line_starts: got %0d expected 8", ls); end
      checks++; if (fs_hi != 1) begin errors++; $display("FAIL frame_strobe_width: got %0d expected 1", fs_hi); end
   endtask

   task automatic test_reset_mid();
      int  cnt;
      bit  seen;
      cnt = 0;
      while (!(s_if.hpos === 16'sd3 && s_if.vpos === 16'sd1) && cnt < 300 * DIV) begin
         tick();
         cnt++;
      end
      checks++; if (s_if.display_on !== 1'b1) begin errors++; $display("FAIL mid_precond: got display_on=%b expected 1", s_if.display_on); end
      reset = 1'b1;
      #1;
      checks++; if (s_if.hpos !== -16'sd6 || s_if.vpos !== -16'sd4) begin errors++; $display("FAIL mid_async_pos: got h=%0d v=%0d expected h=-6 v=-4", s_if.hpos, s_if.vpos); end
      checks++; if (s_if.hsync !== 1'b1 || s_if.vsync !== 1'b1 || s_if.display_on !== 1'b0) begin errors++; $display("FAIL mid_async_flags: got hs=%b vs=%b de=%b expected 1 1 0", s_if.hsync, s_if.vsync, s_if.display_on); end
      repeat (2) tick();
      checks++; if (s_if.hpos !== -16'sd6 || s_if.line_start !== 1'b0) begin errors++; $display("FAIL mid_hold: got h=%0d ls=%b expected h=-6 ls=0", s_if.hpos, s_if.line_start); end
      reset = 1'b0;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 200) begin
         tick();
         cnt++;
         if (s_if.line_start === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen || cnt != LINE * DIV) begin errors++; $display("FAIL mid_first_line_start: got %0d clk expected %0d", cnt, LINE * DIV); end
   endtask

   task automatic test_default();
      int               cnt, n, hs_low;
      logic signed [15:0] first_h, v0;
      cnt = 0;
      while (d_if.line_start !== 1'b1 && cnt < 1000 * DIV) begin
         tick();
         cnt++;
      end
      v0 = d_if.vpos;
      first_h = 16'sd0;
      n = 0; hs_low = 0;
      do begin
         if (d_if.hsync === 1'b0) begin
            if (hs_low == 0) first_h = d_if.hpos;
            hs_low++;
         end
         tick();
         n++;
      end while (d_if.line_start !== 1'b1 && n < 2000 * DIV);
      checks++; if (n != 800 * DIV) begin errors++; $display("FAIL def_line_period: got %0d expected %0d", n, 800 * DIV); end
      checks++; if (hs_low != 96 * DIV) begin errors++; $display("FAIL def_hsync_low: got %0d expected %0d", hs_low, 96 * DIV); end
      checks++; if (first_h !== -16'sd144) begin errors++; $display("FAIL def_hsync_start: got %0d expected -144", first_h); end
      checks++; if (d_if.vpos !== v0 + 16'sd1) begin errors++; $display("FAIL def_vpos_step: got %0d expected %0d", d_if.vpos, v0 + 16'sd1); end
   endtask

   initial begin
      test_reset();
      test_line(-3);
      test_line(0);
      test_line(3);
      test_frame();
      test_reset_mid();
      test_default();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
